// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: LSU results go straight to the output stage, ALU results queue in a FIFO.
// Optional macro WB_BYPASS_EN lets an ALU result skip the empty FIFO when no LSU result competes.
module regfile_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [4:0]        alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [4:0]        lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              reg_wen_o,
  output logic [31:0]       pending_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NREGS = 32;

  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic full;
  logic empty;
  logic alu_acc;
  logic lsu_acc;
  logic bypass;
  logic push;
  logic pop;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign alu_ready_o = ~full & ~rst_i;
  assign lsu_ready_o = ~full & ~rst_i;
  assign alu_acc     = alu_valid_i & alu_ready_o;
  assign lsu_acc     = lsu_valid_i & lsu_ready_o;

`ifdef WB_BYPASS_EN
  assign bypass = empty & ~lsu_valid_i & alu_acc;
`else
  assign bypass = 1'b0;
`endif

  // LSU wins the output stage; the FIFO head drains whenever the LSU is idle or stalled by a full FIFO.
  assign pop  = ~rst_i & ~lsu_acc & ~empty;
  assign push = alu_acc & ~bypass;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
      reg_wen_o <= 1'b0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= alu_rd_i;
        fifo_data[wr_ptr] <= alu_data_i;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // x0 writes consume their slot but leave the output registers untouched.
      reg_wen_o <= 1'b0;
      if (lsu_acc) begin
        if (lsu_rd_i != 5'd0) begin
          reg_wen_o <= 1'b1;
          rd_addr_o <= lsu_rd_i;
          rd_data_o <= lsu_data_i;
        end
      end else if (bypass) begin
        if (alu_rd_i != 5'd0) begin
          reg_wen_o <= 1'b1;
          rd_addr_o <= alu_rd_i;
          rd_data_o <= alu_data_i;
        end
      end else if (pop) begin
        if (fifo_rd[rd_ptr] != 5'd0) begin
          reg_wen_o <= 1'b1;
          rd_addr_o <= fifo_rd[rd_ptr];
          rd_data_o <= fifo_data[rd_ptr];
        end
      end
    end
  end

  // Pending-write mask: every live FIFO entry plus the output stage while it is writing.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [NREGS-1:0] mask;
    mask = '0;
    idx  = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        mask = mask | (NREGS'(1) << fifo_rd[idx]);
      end
    end
    if (reg_wen_o) begin
      mask = mask | (NREGS'(1) << rd_addr_o);
    end
    mask[0]   = 1'b0;
    pending_o = mask;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [DW-1:0] lsu_data;
  logic [4:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          reg_wen;
  logic [31:0]   pending;

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
    .rd_addr_o(rd_addr), .rd_data_o(rd_data), .reg_wen_o(reg_wen), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  // Reference: queued ALU results plus the state of the write port.
  ent_t          mq[$];
  logic          m_wen;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  bit            m_alu_acc;

  int            n_err;
  int            n_chk;
  bit            rec_en;
  logic [4:0]    obs_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    if (m_wen) p[m_addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock cycle: apply inputs, compare visible state, then advance the model across the edge.
  task automatic cycle(input logic r, input logic av, input logic [4:0] ard, input logic [DW-1:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld);
    bit   rdy;
    bit   lacc;
    bit   byp;
    ent_t e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    rdy = !r && (mq.size() < DEPTH);
    check_eq("alu_ready", alu_ready, rdy);
    check_eq("lsu_ready", lsu_ready, rdy);
    check_eq("reg_wen", reg_wen, m_wen);
    check_eq("rd_addr", rd_addr, m_addr);
    check_eq("rd_data", rd_data, m_data);
    check_eq("pending", pending, model_pending());
    if (rec_en && reg_wen) obs_q.push_back(rd_addr);

    m_alu_acc = 1'b0;
    if (r) begin
      mq.delete();
      m_wen = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      lacc      = lv && rdy;
      m_alu_acc = av && rdy;
      byp       = BYP && (mq.size() == 0) && !lv && m_alu_acc;
      m_wen     = 1'b0;
      if (lacc) begin
        if (lrd != 0) begin m_wen = 1'b1; m_addr = lrd; m_data = ld; end
      end else if (byp) begin
        if (ard != 0) begin m_wen = 1'b1; m_addr = ard; m_data = ad; end
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.rd != 0) begin m_wen = 1'b1; m_addr = e.rd; m_data = e.data; end
      end
      if (m_alu_acc && !byp) mq.push_back('{rd: ard, data: ad});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    n_err = 0; n_chk = 0; rec_en = 1'b0;
    m_wen = 1'b0; m_addr = '0; m_data = '0;
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2;

    // Reset held with traffic present.
    cycle(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    cycle(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    check_eq("rst_ready", alu_ready, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check_eq("rel_ready", alu_ready, 1'b1);
    check_eq("rel_wen", reg_wen, 1'b0);
    check_eq("rel_pend", pending, 32'h0);
    idle(2);

    // Single ALU write to x5.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check_eq("single_pend1", pending[5], 1'b1);
    check_eq("single_wen1", reg_wen, BYP);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check_eq("single_wen2", reg_wen, !BYP);
    check_eq("single_pend2", pending[5], !BYP);
    if (!BYP) begin
      check_eq("single_addr", rd_addr, 5'd5);
      check_eq("single_data", rd_data, 32'hDEADBEEF);
    end
    idle(2);

    // Collision: LSU first, ALU one cycle later.
    cycle(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check_eq("coll_addr1", rd_addr, 5'd2);
    check_eq("coll_data1", rd_data, 32'h22);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check_eq("coll_wen2", reg_wen, 1'b1);
    check_eq("coll_addr2", rd_addr, 5'd1);
    check_eq("coll_data2", rd_data, 32'h11);
    idle(2);

    // Backpressure: LSU always valid, ALU pushes x3..x7.
    begin
      int k;
      int acc_before_stall;
      bit stalled;
      k = 0; acc_before_stall = 0; stalled = 1'b0;
      rec_en = 1'b1;
      obs_q.delete();
      for (int c = 0; c < 40 && k < 5; c++) begin
        cycle(1'b0, 1'b1, 5'(3 + k), 32'h100 + 32'(k), 1'b1, 5'(10 + (c % 8)), $urandom);
        if (!alu_ready) stalled = 1'b1;
        if (m_alu_acc) begin
          k++;
          if (!stalled) acc_before_stall++;
        end
      end
      check_eq("bp_all_acc", 64'(k), 64'd5);
      check_eq("bp_acc_before_stall", 64'(acc_before_stall), 64'd4);
      idle(8);
      rec_en = 1'b0;
      begin
        logic [4:0] alu_seen[$];
        foreach (obs_q[i]) if (obs_q[i] >= 5'd3 && obs_q[i] <= 5'd7) alu_seen.push_back(obs_q[i]);
        check_eq("bp_count", 64'(alu_seen.size()), 64'd5);
        for (int i = 0; i < alu_seen.size() && i < 5; i++) check_eq("bp_order", alu_seen[i], 5'(3 + i));
      end
    end

    // x0 requests from both sources.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      check_eq("x0_wen", reg_wen, 1'b0);
      check_eq("x0_pend", pending, 32'h0);
    end

    // Reset with three ALU entries queued behind LSU traffic.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'(20 + i), $urandom, 1'b1, 5'(12 + i), $urandom);
    cycle(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check_eq("midrst_pend", pending, 32'h0);
    check_eq("midrst_wen", reg_wen, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      check_eq("midrst_stale", reg_wen, 1'b0);
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
